// File: rtl/quux_reader.sv
// Serial quux bit receiver: packs LSB-first bits into WIDTH-bit words and
// queues them in a DEPTH-entry FIFO, tagging words that in_last cut short.
module quux_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_quux,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_partial,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               word_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = AW + 1;

  logic [IW-1:0]                 idx_q, idx_d;
  logic [WIDTH-1:0]              shift_q, shift_d;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
  logic [DEPTH-1:0]              part_q, part_d;
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [7:0]                    word_cnt_q, word_cnt_d;

  logic             accept, at_top, push, pop;
  logic [WIDTH-1:0] merged;

  // Ready depends on registered occupancy only, never on out_ready.
  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_partial = out_valid ? part_q[rd_ptr_q] : 1'b0;
  assign count       = count_q;
  assign word_cnt    = word_cnt_q;

  always_comb begin
    accept = in_valid && in_ready;
    at_top = (idx_q == IW'(WIDTH - 1));
    push   = accept && (at_top || in_last);
    pop    = out_valid && out_ready;

    // Bits above idx are still zero, so the closing word needs no masking.
    merged         = shift_q;
    merged[idx_q]  = in_quux;

    idx_d      = idx_q;
    shift_d    = shift_q;
    mem_d      = mem_q;
    part_d     = part_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    word_cnt_d = word_cnt_q;

    if (accept) begin
      if (push) begin
        idx_d            = '0;
        shift_d          = '0;
        mem_d[wr_ptr_q]  = merged;
        part_d[wr_ptr_q] = in_last && !at_top;
        wr_ptr_d         = wr_ptr_q + AW'(1);
        word_cnt_d       = word_cnt_q + 8'd1;
      end else begin
        idx_d   = idx_q + IW'(1);
        shift_d = merged;
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      shift_q    <= '0;
      mem_q      <= '0;
      part_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      mem_q      <= mem_d;
      part_q     <= part_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
    end
  end
endmodule

// File: tb/tb_quux_reader.sv
// Bench for quux_reader: vector table, directed corner sequences, and a
// randomized run checked against a queue-based model of the receiver.
module tb_quux_reader;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0, in_quux = 1'b0, in_last = 1'b0;
  logic         in_ready, out_valid, out_partial;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic [7:0]   word_cnt;

  int total = 0;
  int bad   = 0;

  quux_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_quux(in_quux),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_partial(out_partial), .out_ready(out_ready),
    .count(count), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] bits;
    logic       last;
    logic [7:0] exp_d;
    logic       exp_p;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } ent_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; in_quux = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic l);
    in_valid = 1'b1; in_quux = b; in_last = l;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int n, input logic l);
    for (int i = 0; i < n; i++) send_bit(w[i], l && (i == n - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[6];
    ent_t       mq[$];
    ent_t       e;
    logic [7:0] exp_q[4];
    logic       exp_pq[4];
    logic [7:0] acc;
    int         nb, wc, rp;
    logic       b, pop, acc_ok;

    tbl[0] = '{8, 8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{3, 8'h03, 1'b1, 8'h03, 1'b1};
    tbl[2] = '{8, 8'hFF, 1'b0, 8'hFF, 1'b0};
    tbl[3] = '{1, 8'h01, 1'b1, 8'h01, 1'b1};
    tbl[4] = '{7, 8'h7F, 1'b1, 8'h7F, 1'b1};
    tbl[5] = '{8, 8'h3C, 1'b0, 8'h3C, 1'b0};

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_partial", out_partial, 0);

    // Vector table: one frame per row, held then popped
    for (int r = 0; r < 6; r++) begin
      send_word(tbl[r].bits, tbl[r].n, tbl[r].last);
      chk($sformatf("vec%0d_valid", r), out_valid, 1);
      chk($sformatf("vec%0d_data", r), out_data, tbl[r].exp_d);
      chk($sformatf("vec%0d_partial", r), out_partial, tbl[r].exp_p);
      chk($sformatf("vec%0d_count", r), count, 1);
      chk($sformatf("vec%0d_word_cnt", r), word_cnt, r + 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("vec%0d_pop_count", r), count, 0);
      chk($sformatf("vec%0d_pop_data", r), out_data, 0);
    end

    // Fill to full, stall held bits, pop once, accept, drain
    do_reset();
    for (int k = 1; k <= 4; k++) send_word(8'(k), 8, 1'b0);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_quux = 1'b1; in_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_hold_count", count, 4);
    chk("full_hold_word_cnt", word_cnt, 4);
    chk("full_hold_head", out_data, 8'h01);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("full_pop_in_ready", in_ready, 1);
    chk("full_pop_count", count, 3);
    chk("full_pop_head", out_data, 8'h02);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("full_refill_count", count, 4);
    chk("full_refill_in_ready", in_ready, 0);
    chk("full_refill_word_cnt", word_cnt, 5);
    exp_q  = '{8'h02, 8'h03, 8'h04, 8'h01};
    exp_pq = '{1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_data", i), out_data, exp_q[i]);
      chk($sformatf("drain%0d_partial", i), out_partial, exp_pq[i]);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);

    // Push and pop on the same edge
    do_reset();
    send_word(8'h11, 8, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'(8'h22 >> i), 1'b0);
    in_valid = 1'b1; in_quux = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    chk("simul_popped", out_data, 8'h11);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("simul_count", count, 1);
    chk("simul_head", out_data, 8'h22);
    chk("simul_partial", out_partial, 0);
    chk("simul_word_cnt", word_cnt, 2);

    // Asynchronous reset mid-word with stored words
    do_reset();
    send_word(8'h55, 8, 1'b0);
    send_word(8'h66, 8, 1'b0);
    send_word(8'h1F, 5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_word_cnt", word_cnt, 0);
    chk("arst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_word(8'h3C, 8, 1'b0);
    chk("arst_after_data", out_data, 8'h3C);
    chk("arst_after_partial", out_partial, 0);
    chk("arst_after_count", count, 1);

    // 256 single-bit frames with continuous popping: word_cnt wraps
    do_reset();
    out_ready = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b = 1'($urandom_range(0, 1));
      in_quux = b;
      @(negedge clk);
      chk($sformatf("wrap%0d_data", i), out_data, {7'd0, b});
      chk($sformatf("wrap%0d_count", i), count, 1);
      if (i >= 254) chk($sformatf("wrap%0d_word_cnt", i), word_cnt, (i + 1) % 256);
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("wrap_end_count", count, 0);
    chk("wrap_end_word_cnt", word_cnt, 0);

    // Randomized run against a queue model
    do_reset();
    mq.delete();
    acc = '0; nb = 0; wc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_out_valid", out_valid, mq.size() != 0);
      chk("rnd_in_ready", in_ready, mq.size() != D);
      chk("rnd_count", count, mq.size());
      chk("rnd_word_cnt", word_cnt, wc);
      chk("rnd_out_data", out_data, (mq.size() != 0) ? mq[0].d : 8'h00);
      chk("rnd_out_partial", out_partial, (mq.size() != 0) ? mq[0].p : 1'b0);

      rp        = ((cyc / 400) % 2 == 1) ? 80 : 25;
      in_valid  = ($urandom_range(0, 99) < 70);
      in_quux   = 1'($urandom_range(0, 1));
      in_last   = ($urandom_range(0, 99) < 12);
      out_ready = ($urandom_range(0, 99) < rp);

      acc_ok = in_valid && (mq.size() != D);
      pop    = (mq.size() != 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (acc_ok) begin
        acc = acc | (8'(in_quux) << nb);
        nb++;
        if (nb == W || in_last) begin
          e.d = acc;
          e.p = (nb != W);
          mq.push_back(e);
          acc = '0; nb = 0;
          wc = (wc + 1) % 256;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/quux_reader.md
# quux_reader

Receiving end of the serial `quux` bit interface: accepts a valid/ready bit stream LSB-first, packs bits into WIDTH-bit words, and buffers completed words in a DEPTH-entry FIFO for a word-level consumer. It sits in the consuming module of a test hierarchy, opposite the block that drives `quux`. It counts delivered words for self-checking benches.

## Interface
- `WIDTH`, 8, bits per packed word (>= 2)
- `DEPTH`, 4, FIFO entries (power of 2, >= 2)
- `clk`  input  1  sole clock, all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  bit present on `in_quux`
- `in_quux`  input  1  serial data bit
- `in_last`  input  1  final bit of a frame; qualified by `in_valid`
- `in_ready`  output  1  block accepts a bit this cycle
- `out_valid`  output  1  FIFO head valid
- `out_data`  output  WIDTH  FIFO head word
- `out_partial`  output  1  head word was closed early by `in_last`
- `out_ready`  input  1  consumer pops head when `out_valid` is also high
- `count`  output  $clog2(DEPTH)+1  words currently stored
- `word_cnt`  output  8  words pushed since reset, wraps modulo 256

## Operation
- Bit accept: `in_valid && in_ready` at a rising edge. Accepted bit is written to shift-register position `idx`; `idx` counts 0..WIDTH-1.
- Word close: on an accepted bit with `idx == WIDTH-1` or `in_last`. Closed word (including current bit, unfilled upper bits zero) is pushed into FIFO on that same edge; `idx` and shift register clear to 0.
- `out_partial` stored per entry: 1 when closed by `in_last` with `idx != WIDTH-1`; 0 otherwise (including `in_last` exactly on bit WIDTH-1).
- `in_ready = (count != DEPTH)`; purely from registered state, no combinational dependence on `out_ready`. While full, no bits accepted, including bits that would not close a word.
- Pop: `out_valid && out_ready` removes head. `out_valid = (count != 0)`.
- Simultaneous push and pop: `count` unchanged; pop gets old head, pushed word goes to tail.
- `out_data` and `out_partial` drive 0 when `count == 0`.
- `word_cnt` increments by 1 per pushed word, 255 -> 0 wraps silently.
- Read/write pointers `$clog2(DEPTH)` bits, wrap naturally; full/empty from `count` only.
- Inputs other than `in_valid` are don't-care when `in_valid` is low; `in_last` without `in_valid` has no effect.

## Timing
- Reset (asynchronous assert, takes effect immediately; synchronous-safe release): `idx`=0, shift register=0, pointers=0, `count`=0, `word_cnt`=0, `out_valid`=0, `out_data`=0, `out_partial`=0, `in_ready`=1.
- Reset mid-word discards accumulated bits; reset with words stored discards them; no partial word is emitted.
- Latency: closing bit accepted at edge N -> `out_valid` high, `out_data` valid in cycle after edge N (one cycle, no bypass).
- Throughput: one bit per cycle sustained while not full; back-to-back words need no idle cycle.
- Full: push closing word at edge N makes `count == DEPTH` -> `in_ready` low after edge N. Pop at edge M -> `in_ready` high after edge M; earliest next bit accepted at edge M+1.
- `out_data` stable while `out_valid && !out_ready`.

## Test plan
- Word 0xA5 sent LSB-first (bits 1,0,1,0,0,1,0,1), `in_last` on 8th, `out_ready`=0 -> cycle after 8th accept: `out_valid`=1, `out_data`=0xA5, `out_partial`=0, `count`=1, `word_cnt`=1.
- Partial frame bits 1,1,0 with `in_last` on 3rd -> `out_data`=0x03, `out_partial`=1; following full word 0xFF lands as 0xFF with no leftover bits.
- `out_ready`=0, push 0x01,0x02,0x03,0x04 -> `count`=4, `in_ready`=0, held `in_valid` bits not consumed; pulse `out_ready` one cycle -> 0x01 popped, `in_ready`=1 next cycle; drain yields 0x02,0x03,0x04 in order.
- With `count`=1 (head 0x11), close word 0x22 on the same edge as a pop -> `count` stays 1, popped value 0x11, new head 0x22.
- After 5 bits of a word and 2 stored words, assert `rst` between edges -> `count`=0, `out_valid`=0, `in_ready`=1, `word_cnt`=0 without a clock edge; after release, word 0x3C received exactly.
- Push 256 single-bit frames while popping continuously -> `word_cnt` reaches 255 then wraps to 0; no entry lost or duplicated.
